// File: rtl/reg_bank_scan_seq_if.sv
// Bus bundle between the lab datapath and the register bank / select sequencer.
// The slave side is the bank; the master side loads entries and runs scans.
interface reg_bank_scan_seq_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             stop;
    logic             loop_en;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [2:0]       sel;
    logic             busy;
    logic             done;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, loop_en,
        input  a, b, c, d, e, f, g, h, sel, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, loop_en,
        output a, b, c, d, e, f, g, h, sel, busy, done
    );
endinterface

// File: rtl/reg_bank_scan_seq.sv
// Eight-entry register bank feeding an 8-to-1 byte mux, plus a sequencer
// that steps the mux select through 0..7, holding each index HOLD_CYCLES clocks.
//
// state     | meaning
// ST_IDLE   | Sel parked at 0, waiting for Start
// ST_SCAN   | stepping Sel; cnt_q counts clocks spent on the current index
module reg_bank_scan_seq #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    reg_bank_scan_seq_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [WIDTH-1:0] regs_q [8];
    logic [1:0]       state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.wr_en) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sel_d = 3'd0;
                cnt_d = 8'd0;
                if (bus.start && !bus.stop) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    sel_d   = 3'd0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else if (sel_q != 3'd7) begin
                    sel_d = sel_q + 3'd1;
                    cnt_d = 8'd0;
                end else if (bus.loop_en) begin
                    sel_d = 3'd0;
                    cnt_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                    sel_d   = 3'd0;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = 3'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.a    = regs_q[0];
    assign bus.b    = regs_q[1];
    assign bus.c    = regs_q[2];
    assign bus.d    = regs_q[3];
    assign bus.e    = regs_q[4];
    assign bus.f    = regs_q[5];
    assign bus.g    = regs_q[6];
    assign bus.h    = regs_q[7];
    assign bus.sel  = sel_q;
    assign bus.busy = (state_q == ST_SCAN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_reg_bank_scan_seq.sv
// Bench for reg_bank_scan_seq: two instances (hold 2 and hold 1) share stimulus
// and are compared every cycle against a scan-position model of the bank.
module tb_reg_bank_scan_seq;
    localparam int H0 = 2;
    localparam int H1 = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic       stop;
    logic       loop_en;

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank_scan_seq_if #(.WIDTH(8)) if0 ();
    reg_bank_scan_seq_if #(.WIDTH(8)) if1 ();

    assign if0.wr_en = wr_en;   assign if1.wr_en = wr_en;
    assign if0.wr_addr = wr_addr; assign if1.wr_addr = wr_addr;
    assign if0.wr_data = wr_data; assign if1.wr_data = wr_data;
    assign if0.start = start;   assign if1.start = start;
    assign if0.stop = stop;     assign if1.stop = stop;
    assign if0.loop_en = loop_en; assign if1.loop_en = loop_en;

    reg_bank_scan_seq #(.WIDTH(8), .HOLD_CYCLES(H0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0));
    reg_bank_scan_seq #(.WIDTH(8), .HOLD_CYCLES(H1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1));

    always #5 clk = ~clk;

    // Model: a scan is a position 0..8*hold-1; Sel is position / hold.
    logic [7:0] m_regs [8];
    int         m_pos  [2];
    bit         m_busy [2];
    bit         m_done [2];
    bit         m_valid = 1'b0;
    int         hold   [2] = '{H0, H1};

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            for (int i = 0; i < 2; i++) begin
                m_pos[i] = 0; m_busy[i] = 0; m_done[i] = 0;
            end
            m_valid = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 0;
                if (!m_busy[i]) begin
                    if (start && !stop) begin
                        m_busy[i] = 1; m_pos[i] = 0;
                    end
                end else if (stop) begin
                    m_busy[i] = 0;
                end else if (m_pos[i] == 8 * hold[i] - 1) begin
                    if (loop_en) m_pos[i] = 0;
                    else begin
                        m_busy[i] = 0; m_done[i] = 1;
                    end
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
            if (wr_en) m_regs[wr_addr] = wr_data;
        end
    end

    function automatic logic [63:0] model_pack();
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = m_regs[i];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    wire [63:0] pk0 = {if0.h, if0.g, if0.f, if0.e, if0.d, if0.c, if0.b, if0.a};
    wire [63:0] pk1 = {if1.h, if1.g, if1.f, if1.e, if1.d, if1.c, if1.b, if1.a};

    always @(negedge clk) begin
        if (m_valid) begin
            chk("regs0", pk0, model_pack());
            chk("sel0", 64'(if0.sel), m_busy[0] ? 64'(m_pos[0] / hold[0]) : 64'd0);
            chk("busy0", 64'(if0.busy), 64'(m_busy[0]));
            chk("done0", 64'(if0.done), 64'(m_done[0]));
            chk("regs1", pk1, model_pack());
            chk("sel1", 64'(if1.sel), m_busy[1] ? 64'(m_pos[1] / hold[1]) : 64'd0);
            chk("busy1", 64'(if1.busy), 64'(m_busy[1]));
            chk("done1", 64'(if1.done), 64'(m_done[1]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // what: 0 = wait for dut0 scanning at Sel k, 1 = wait for dut0 Done
    task automatic wait_dut0(input int what, input logic [2:0] k, input string nm);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (what == 0) found = if0.busy && (if0.sel == k);
            else           found = if0.done;
            if (!found) cyc();
        end
        chk(nm, 64'(found), 64'd1);
    endtask

    initial begin
        int busy_cnt, done_at, done_cnt;
        logic [63:0] lit;
        logic [7:0]  y;

        rst = 1; wr_en = 0; wr_addr = 0; wr_data = 0; start = 0; stop = 0; loop_en = 0;
        cyc(); cyc();
        chk("reset_sel", 64'(if0.sel), 64'd0);
        chk("reset_regs", pk0, 64'd0);
        rst = 0;

        // 1: load entries
        for (int i = 0; i < 8; i++) begin
            wr_en = 1; wr_addr = 3'(i); wr_data = 8'((i + 1) * 17);
            cyc();
            chk("wr_visible", 64'(pk0[i*8 +: 8]), 64'((i + 1) * 17));
        end
        wr_en = 0;
        lit = 64'h8877665544332211;
        chk("load_all", pk0, lit);
        chk("idle_busy", 64'(if0.busy), 64'd0);

        // 2: single scan, hold 2
        start = 1; cyc(); start = 0;
        busy_cnt = 0; done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            if (if0.busy) busy_cnt++;
            if (if0.done && done_at == 0) done_at = c;
            if (c <= 16) begin
                y = pk0[if0.sel*8 +: 8];
                chk("y_seq", 64'(y), 64'(((c - 1) / 2 + 1) * 17));
            end
            cyc();
        end
        chk("busy_len", 64'(busy_cnt), 64'd16);
        chk("done_cycle", 64'(done_at), 64'd17);

        // 3: looping scan then stop
        loop_en = 1; start = 1; cyc(); start = 0;
        done_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (if0.done) done_cnt++;
            if (c == 17) chk("wrap_sel", {60'd0, if0.busy, if0.sel}, 64'h8);
            if (c < 20) cyc();
        end
        chk("loop_no_done", 64'(done_cnt), 64'd0);
        stop = 1; cyc(); stop = 0; loop_en = 0;
        chk("stop_state", {61'd0, if0.busy, if0.done, 1'b0} | 64'(if0.sel), 64'd0);

        // 4: write to selected entry mid-scan; Start pulses ignored
        start = 1; cyc(); start = 0;
        wait_dut0(0, 3'd3, "wait_sel3");
        wr_en = 1; wr_addr = 3'd3; wr_data = 8'hA5; cyc(); wr_en = 0;
        chk("mid_write", 64'(if0.d), 64'hA5);
        for (int i = 0; i < 3; i++) begin
            start = 1; cyc(); start = 0; cyc();
        end
        wait_dut0(1, 3'd0, "wait_done4");
        cyc();

        // 5: reset mid-scan with a competing write
        start = 1; cyc(); start = 0;
        wait_dut0(0, 3'd5, "wait_sel5");
        rst = 1; wr_en = 1; wr_addr = 3'd5; wr_data = 8'hFF; cyc();
        rst = 0; wr_en = 0;
        chk("rst_regs", pk0, 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);

        // 6: Start+Stop in IDLE, then Start in the Done cycle
        start = 1; stop = 1; cyc(); start = 0; stop = 0;
        chk("start_stop_idle", 64'(if0.busy), 64'd0);
        start = 1; cyc(); start = 0;
        wait_dut0(1, 3'd0, "wait_done6");
        start = 1; cyc(); start = 0;
        chk("restart_busy", 64'(if0.busy), 64'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst     = ($urandom_range(63) == 0);
            wr_en   = ($urandom_range(2) == 0);
            wr_addr = 3'($urandom_range(7));
            wr_data = 8'($urandom);
            start   = ($urandom_range(7) == 0);
            stop    = ($urandom_range(40) == 0);
            loop_en = $urandom_range(1) == 1;
            cyc();
        end
        rst = 0; wr_en = 0; start = 0; stop = 0; loop_en = 0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
